// File: rtl/ps2_scan_fifo_pkg.sv
// Shared constants and types for the PS/2 scan-code front end.
package ps2_pkg;

  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned ENTRY_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_scan_fifo_if.sv
// Valid/ready read port carrying decoded key events.
interface ps2_scan_fifo_if;

  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_code;
  logic       rd_break;
  logic       rd_ext;

  modport master (output rd_valid, rd_code, rd_break, rd_ext, input rd_ready);
  modport slave  (input rd_valid, rd_code, rd_break, rd_ext, output rd_ready);

endinterface

// File: rtl/ps2_scan_fifo_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, framing FSM,
// inactivity watchdog and odd-parity/stop check.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [7:0] code,
  output logic       frame_tmo
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  rx_state_t  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] sh_q, sh_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic       done_d, ok_d, tmo_d;
  logic [7:0] code_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Pin synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_q <= clk_s;
    end
  end

  // Receive state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      wdog_q     <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      code       <= '0;
      frame_tmo  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      wdog_q     <= wdog_d;
      frame_done <= done_d;
      frame_ok   <= ok_d;
      code       <= code_d;
      frame_tmo  <= tmo_d;
    end
  end

  // Next state: data+parity shift in LSB first; stop bit closes the frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    wdog_d    = wdog_q;
    done_d    = 1'b0;
    ok_d      = frame_ok;
    code_d    = code;
    tmo_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
          wdog_d    = '0;
        end
      end
      RECV: begin
        if (fall) begin
          wdog_d = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d = CHECK;
            done_d  = 1'b1;
            ok_d    = dat_s & (^sh_q);
            code_d  = sh_q[7:0];
          end else begin
            sh_d      = {dat_s, sh_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard front end: prefix folding, key-event FIFO and error count.
module ps2_scan_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  input  logic                   clr_overflow,
  ps2_scan_fifo_if.master        rd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [ERR_W-1:0]       frame_err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic       frame_done, frame_ok, frame_tmo;
  logic [7:0] frame_code;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (CLOCK_50),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .code       (frame_code),
    .frame_tmo  (frame_tmo)
  );

  logic       ext_pend_q, brk_pend_q;
  logic       good, is_ext, is_brk, push;
  ps2_entry_t wr_entry;

  assign good     = frame_done & frame_ok;
  assign is_ext   = frame_code == PS2_PREFIX_EXT;
  assign is_brk   = frame_code == PS2_PREFIX_BRK;
  assign push     = good & ~is_ext & ~is_brk;
  assign wr_entry = '{ext: ext_pend_q, brk: brk_pend_q, code: frame_code};

  // Prefix flags accumulate until the next non-prefix code consumes them.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (good) begin
      if (is_ext) begin
        ext_pend_q <= 1'b1;
      end else if (is_brk) begin
        brk_pend_q <= 1'b1;
      end else begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  ps2_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, pop, wr_en;
  ps2_entry_t      head;

  assign full        = count_q == CW'(DEPTH);
  assign rd.rd_valid = count_q != '0;
  assign pop         = rd.rd_valid & rd.rd_ready;
  assign wr_en       = push & (~full | pop);
  assign head        = rd.rd_valid ? mem[rd_ptr_q] : '0;
  assign rd.rd_code  = head.code;
  assign rd.rd_break = head.brk;
  assign rd.rd_ext   = head.ext;
  assign fifo_count  = count_q;

  // Storage array; contents are only observed through the valid-gated head.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  // Pointers, occupancy and sticky overflow (a new drop beats a clear).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  // Saturating count of bad frames and watchdog timeouts.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_err_cnt <= '0;
    end else if (((frame_done && !frame_ok) || frame_tmo) && (frame_err_cnt != '1)) begin
      frame_err_cnt <= frame_err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Randomised bench for ps2_scan_fifo with a queue-based reference model.
module tb_ps2_scan_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned T     = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       clr_overflow;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] frame_err_cnt;

  ps2_scan_fifo_if rd_if ();

  ps2_scan_fifo #(
    .DEPTH          (DEPTH),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (T),
    .ERR_W          (8)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .clr_overflow  (clr_overflow),
    .rd            (rd_if),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [9:0] q[$];
  bit         m_ext = 0, m_brk = 0, m_ovf = 0;
  int         m_err = 0;
  longint     cyc = 0;
  longint     ev_due = -1;
  longint     tmo_due = -1;
  logic [7:0] ev_code;
  bit         ev_ok;
  bit         m_pop, m_push, m_drop;
  logic [9:0] m_entry;

  bit chk_en   = 0;
  bit skip_err = 0;
  bit rnd_rdy  = 0;
  int rdy_pct  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a completed frame takes effect on the 4th edge after its stop-bit
  // falling edge is driven (2 synchroniser edges, then CHECK, then push).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
    end else begin
      m_pop  = (q.size() != 0) && (rd_if.rd_ready === 1'b1);
      m_push = 0;
      m_drop = 0;
      if (cyc == ev_due) begin
        if (!ev_ok) begin
          if (m_err < 255) m_err++;
        end else if (ev_code == 8'hE0) m_ext = 1;
        else if (ev_code == 8'hF0) m_brk = 1;
        else begin
          m_push  = 1;
          m_entry = {m_ext, m_brk, ev_code};
          m_ext = 0; m_brk = 0;
        end
      end
      if (cyc == tmo_due && m_err < 255) m_err++;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (q.size() < DEPTH) q.push_back(m_entry);
        else m_drop = 1;
      end
      if (m_drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(rd_if.rd_valid), 32'(q.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (!skip_err) check("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
      if (q.size() != 0)
        check("head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'(q[0]));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) rd_if.rd_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic ps2_bit(input logic b, input bit last, input logic [7:0] code,
                         input bit ok, input bit pop_at_push);
    ps2_dat = b;
    repeat (4) tick();
    ps2_clk = 1'b0;
    if (last) begin
      ev_code = code;
      ev_ok   = ok;
      ev_due  = cyc + 4;
    end
    if (last && pop_at_push) begin
      repeat (3) tick();
      rd_if.rd_ready = 1'b1;
      tick();
      rd_if.rd_ready = 1'b0;
      repeat (4) tick();
    end else begin
      repeat (8) tick();
    end
    ps2_clk = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par,
                            input bit bad_stop, input bit pop_at_push);
    logic [10:0] bits;
    bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++)
      ps2_bit(bits[i], i == 10, code, !bad_par && !bad_stop, pop_at_push);
    ps2_dat = 1'b1;
    repeat (2) tick();
  endtask

  task automatic pop1();
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  function automatic logic [7:0] rnd_code();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
    return c;
  endfunction

  logic [7:0] codes [9];
  logic [7:0] rc;

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    clr_overflow = 1'b0; rd_if.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_code", 32'(rd_if.rd_code), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_err", 32'(frame_err_cnt), 32'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Single make code.
    send_frame(8'h1C, 0, 0, 0);
    check("t1_valid", 32'(rd_if.rd_valid), 32'd1);
    check("t1_head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h01C);
    check("t1_count", 32'(fifo_count), 32'd1);
    pop1();

    // Prefix folding.
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    check("t2_count", 32'(fifo_count), 32'd3);
    check("t2_err", 32'(frame_err_cnt), 32'd0);
    check("t2_head0", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h11C);
    pop1();
    check("t2_head1", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h275);
    pop1();
    check("t2_head2", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h375);
    pop1();

    // Overflow with nine codes into eight entries.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      codes[i] = rnd_code();
      send_frame(codes[i], 0, 0, 0);
    end
    check("t3_count", 32'(fifo_count), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("t3_entry", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'({2'b00, codes[i]}));
      pop1();
    end

    // Bad parity and bad stop bit.
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("t4_err", 32'(frame_err_cnt), 32'd2);
    check("t4_count", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 0, 0, 0);
    check("t4_head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h01C);
    pop1();

    // Watchdog abandons a partial frame.
    do_reset();
    skip_err = 1;
    ps2_bit(1'b0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 0, 8'h00, 0, 0);
    repeat (T + 60) tick();
    check("t5_err", 32'(frame_err_cnt), 32'd1);
    tmo_due = cyc + 1;
    repeat (2) tick();
    skip_err = 0;
    send_frame(8'h29, 0, 0, 0);
    check("t5_head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h029);
    pop1();

    // Simultaneous push and pop while full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      codes[i] = rnd_code();
      send_frame(codes[i], 0, 0, 0);
    end
    send_frame(rnd_code(), 0, 0, 1);
    check("t6_count", 32'(fifo_count), 32'd8);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'({2'b00, codes[1]}));

    // Random traffic: slow consumer, then faster consumer.
    rnd_rdy = 1;
    for (int ph = 0; ph < 2; ph++) begin
      rdy_pct = (ph == 0) ? 1 : 30;
      for (int n = 0; n < 14; n++) begin
        case ($urandom_range(0, 7))
          0:       rc = 8'hE0;
          1:       rc = 8'hF0;
          default: rc = rnd_code();
        endcase
        send_frame(rc, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, 0);
        if ($urandom_range(0, 3) == 0) begin
          clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        end
      end
    end
    rnd_rdy = 0;
    rd_if.rd_ready = 1'b0;

    // Reset in the middle of a frame.
    send_frame(8'h33, 0, 0, 0);
    ps2_dat = 1'b0;
    repeat (4) tick();
    ps2_clk = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("t7_valid", 32'(rd_if.rd_valid), 32'd0);
    check("t7_code", 32'(rd_if.rd_code), 32'd0);
    check("t7_brk", 32'(rd_if.rd_break), 32'd0);
    check("t7_ext", 32'(rd_if.rd_ext), 32'd0);
    check("t7_count", 32'(fifo_count), 32'd0);
    check("t7_ovf", 32'(overflow), 32'd0);
    check("t7_err", 32'(frame_err_cnt), 32'd0);
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    send_frame(8'h1C, 0, 0, 0);
    check("t7_head", 32'({rd_if.rd_ext, rd_if.rd_break, rd_if.rd_code}), 32'h01C);
    check("t7_count1", 32'(fifo_count), 32'd1);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global run-time bound.
  initial begin
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
- Next-generation PS/2 keyboard front end.
- Deserialises PS/2 frames, validates them, folds E0/F0 prefixes into flags, and buffers decoded key events in a parametrised FIFO with a valid/ready read port.
- Replaces the single scan-code latch feeding LEDR, so no key events are lost between reads.
- Sits between the PS/2 pins and the display/game logic in fpga_top.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_dat; minimum 2.
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms).
- ERR_W, 8, width of the frame error counter.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; the only clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  input  1  raw PS/2 data pin, asynchronous.
- rd_ready  input  1  consumer accepts the head entry.
- clr_overflow  input  1  clears the sticky overflow flag.
- rd_valid  output  1  FIFO not empty.
- rd_code  output  8  head entry scan code.
- rd_break  output  1  head entry is a key release (F0-prefixed).
- rd_ext  output  1  head entry is extended (E0-prefixed).
- fifo_count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- overflow  output  1  sticky: an entry was dropped because the FIFO was full.
- frame_err_cnt  output  ERR_W  count of bad frames plus timeouts; saturates at all-ones.

Behaviour:
- Reset values: rd_valid=0, rd_code=0, rd_break=0, rd_ext=0, fifo_count=0, overflow=0, frame_err_cnt=0. Reset also clears both pointers, the prefix pending flags and the receive state machine. Reset mid-frame discards the partial frame.
- Synchronisation: both pins pass through SYNC_STAGES flops. A PS/2 falling edge is the synchronised ps2_clk going 1→0, giving a one-cycle fall pulse.
- Receive state machine:
  - IDLE→RECV on a fall pulse with ps2_dat=0 (start bit). A fall pulse with ps2_dat=1 in IDLE is ignored.
  - RECV samples ps2_dat on each fall pulse: 8 data bits LSB first, then the parity bit, then the stop bit. Bit counter runs 1..10.
  - After the stop-bit sample, go to CHECK for one cycle. The frame is good if stop=1 and the parity over data+parity bits is odd.
  - CHECK→IDLE always.
  - In RECV, no fall pulse for TIMEOUT_CYCLES → go to IDLE and increment frame_err_cnt. The watchdog counter restarts on every fall pulse.
- Error handling: a bad frame in CHECK increments frame_err_cnt (saturating) and produces no push. Prefix flags are unchanged.
- Prefix decode, on a good frame in CHECK:
  - code 8'hE0 sets ext_pend; no push.
  - code 8'hF0 sets brk_pend; no push.
  - Any other code pushes {ext_pend, brk_pend, code}, then clears both flags.
  - Sequence E0 F0 xx yields a single entry with ext=1, break=1.
- Latency: the push is written in the CHECK cycle. rd_valid rises on the next CLOCK_50 edge, 2 cycles after the stop-bit fall pulse is seen by the synchroniser output.
- FIFO:
  - Show-ahead: rd_code, rd_break and rd_ext always reflect the head entry while rd_valid=1. They are don't-care when rd_valid=0.
  - Pop occurs on rd_valid & rd_ready. Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Push while full without a simultaneous pop: the entry is dropped, overflow is set, and fifo_count stays at DEPTH.
  - Push and pop in the same cycle while full: both take effect and count stays at DEPTH.
  - Push and pop in the same cycle while empty: the push takes effect and there is no pop, since rd_valid=0.
  - rd_ready while empty has no effect.
- clr_overflow clears overflow. If clr_overflow and a new overflow occur in the same cycle, set wins.

Decomposition:
- Package ps2_pkg holds:
  - PS2_PREFIX_EXT = 8'hE0.
  - PS2_PREFIX_BRK = 8'hF0.
  - The FIFO entry width, 10.
  - The receive state encoding: IDLE, RECV, CHECK.
- One sub-module, ps2_frame_rx, contains the synchronisers, edge detect, receive state machine, watchdog and parity check. It outputs a one-cycle frame_done pulse with frame_ok and code[7:0].
- Prefix decode, the FIFO and the error counter live in ps2_scan_fifo.

Test Plan:
- Send frame 0x1C with correct odd parity, rd_ready=0 → rd_valid=1, rd_code=0x1C, break=0, ext=0, fifo_count=1.
- Send F0 1C, then E0 75, then E0 F0 75 → entries {0,1,1C}, {1,0,75}, {1,1,75} in order; fifo_count=3, frame_err_cnt=0.
- DEPTH=8: send 9 codes with rd_ready=0 → fifo_count=8, overflow=1, first 8 codes intact. Pulse clr_overflow → overflow=0.
- Send 0x1C with wrong parity, then a frame with stop bit=0 → no push, frame_err_cnt=2. Next good 0x1C is received normally.
- Send start bit plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES+1 → frame_err_cnt=1, FSM in IDLE. A following good frame 0x29 is received correctly.
- With FIFO full, hold rd_ready=1 while a new frame completes → push and pop in the same cycle, fifo_count stays 8, overflow=0. Assert reset mid-frame → all outputs return to reset values.
